// File: rtl/lcd_pkg.sv
// Shared definitions for the multichannel HD44780 telemetry display.
// Holds the LCD command bytes, the ASCII helpers, the top-level FSM state codes,
// the frame layout constants and the channel label ROM. The labels are only used
// when LCD_LABEL_EN is defined.
package lcd_pkg;

  // HD44780 command bytes (8-bit bus, 2 lines, 5x8 font)
  localparam logic [7:0] FUNC_SET    = 8'h38;
  localparam logic [7:0] DISP_ON     = 8'h0C;
  localparam logic [7:0] CLEAR       = 8'h01;
  localparam logic [7:0] ENTRY       = 8'h06;
  localparam logic [7:0] LINE1       = 8'h80;
  localparam logic [7:0] LINE2       = 8'hC0;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_COLON = 8'h3A;

  // Frame layout: LINE1 cmd, 16 chars, LINE2 cmd, 16 chars
  localparam int unsigned INIT_BYTES  = 4;
  localparam int unsigned FRAME_BYTES = 34;
  localparam int unsigned LINE2_IDX   = 17;
  localparam int unsigned IDX_W       = 6;

  // Top-level sequencer states
  localparam logic [1:0] ST_PWRUP = 2'd0;
  localparam logic [1:0] ST_INIT  = 2'd1;
  localparam logic [1:0] ST_IDLE  = 2'd2;
  localparam logic [1:0] ST_FRAME = 2'd3;

  // One hex nibble to its upper-case ASCII character
  function automatic logic [7:0] hex2ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  // Two-character channel labels: VI, VO, IO, TP
  function automatic logic [7:0] label_char(input logic [1:0] ch, input logic second);
    logic [7:0] c;
    case (ch)
      2'd0:    c = second ? 8'h49 : 8'h56;  // "VI"
      2'd1:    c = second ? 8'h4F : 8'h56;  // "VO"
      2'd2:    c = second ? 8'h4F : 8'h49;  // "IO"
      default: c = second ? 8'h50 : 8'h54;  // "TP"
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_write_strobe.sv
// Single-byte LCD write timing engine.
// On start (accepted only when idle) it latches rs/data/wait_cyc, presents RS/DATA
// for one setup cycle, holds lcd_e high for E_PULSE_CYC cycles, then keeps
// lcd_e low with the data still held for wait_cyc cycles and pulses done.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           request a byte write (ignored while busy)
//   rs, data        register select and byte to write
//   wait_cyc        settle time after the strobe (>= 1)
//   done            one-cycle pulse when the byte and its settle time are over
//   lcd_rs/lcd_data/lcd_e  LCD pins
module lcd_write_strobe #(
  parameter int unsigned E_PULSE_CYC = 16,
  parameter int unsigned WAIT_W      = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rs,
  input  logic [7:0]        data,
  input  logic [WAIT_W-1:0] wait_cyc,
  output logic              done,
  output logic              lcd_rs,
  output logic [7:0]        lcd_data,
  output logic              lcd_e
);

  localparam int unsigned PULSE_W = $clog2(E_PULSE_CYC + 1);
  localparam int unsigned CNT_W   = (WAIT_W > PULSE_W) ? WAIT_W : PULSE_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_HIGH  = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              rs_q, rs_d;
  logic [7:0]        data_q, data_d;
  logic              e_q, e_d;
  logic              done_q, done_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      e_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      e_q     <= e_d;
      done_q  <= done_d;
    end
  end

  // Next state: setup cycle, E-high countdown, settle countdown
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    rs_d    = rs_q;
    data_d  = data_q;
    e_d     = e_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rs_d    = rs;
          data_d  = data;
          wait_d  = wait_cyc;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        e_d     = 1'b1;
        cnt_d   = CNT_W'(E_PULSE_CYC - 1);
        state_d = S_HIGH;
      end
      S_HIGH: begin
        if (cnt_q == '0) begin
          e_d     = 1'b0;
          cnt_d   = CNT_W'(wait_q) - CNT_W'(1);
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  assign done     = done_q;
  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;
  assign lcd_e    = e_q;

endmodule

// File: rtl/lcd_multichan_display.sv
// HD44780 16x2 telemetry display for NUM_CH channels of DIGITS hex digits.
// Runs the power-up wait and init commands, then refreshes the screen every
// REFRESH_CYC clocks while iEN is high, from a snapshot of iCH_DATA taken at
// frame start. Line 1 shows ch0/ch1, line 2 ch2/ch3, 8 characters per field.
// Optional build macro LCD_LABEL_EN prefixes each field with "VI:", "VO:",
// "IO:" or "TP:".
// Ports:
//   iCLK_50MHZ   clock
//   iRST_N       synchronous active-low reset
//   iEN          allow refresh frames
//   iCH_DATA     channel nibbles, ch0 at the LSBs
//   oREADY       init sequence complete
//   oFRAME_DONE  one-cycle pulse after the last byte of a frame
//   LCD_DATA, LCD_RS, LCD_RW, LCD_E   LCD pins (write-only, LCD_RW tied 0)
module lcd_multichan_display
  import lcd_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned DIGITS        = 2,
  parameter int unsigned E_PULSE_CYC   = 16,
  parameter int unsigned CHAR_WAIT_CYC = 2000,
  parameter int unsigned CLR_WAIT_CYC  = 100000,
  parameter int unsigned PWRUP_CYC     = 750000,
  parameter int unsigned REFRESH_CYC   = 5000000
) (
  input  logic                         iCLK_50MHZ,
  input  logic                         iRST_N,
  input  logic                         iEN,
  input  logic [NUM_CH*DIGITS*4-1:0]   iCH_DATA,
  output logic                         oREADY,
  output logic                         oFRAME_DONE,
  output logic [7:0]                   LCD_DATA,
  output logic                         LCD_RS,
  output logic                         LCD_RW,
  output logic                         LCD_E
);

  localparam int unsigned DATA_W   = NUM_CH * DIGITS * 4;
  localparam int unsigned WAIT_MAX = (CLR_WAIT_CYC > CHAR_WAIT_CYC) ? CLR_WAIT_CYC : CHAR_WAIT_CYC;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int unsigned PW_W     = $clog2(PWRUP_CYC + 1);
  localparam int unsigned RF_W     = $clog2(REFRESH_CYC + 1);

  logic [1:0]        state_q, state_d;
  logic [PW_W-1:0]   pw_cnt_q, pw_cnt_d;
  logic [RF_W-1:0]   rf_cnt_q, rf_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              pend_q, pend_d;
  logic              ready_q, ready_d;
  logic              fdone_q, fdone_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;

  logic              start_c;
  logic              wr_done;
  logic              byte_rs_c;
  logic [7:0]        byte_data_c;
  logic [WAIT_W-1:0] byte_wait_c;

  logic              line_c;
  logic [3:0]        col_c;
  logic [1:0]        field_c;
  logic [2:0]        pos_c;
  logic              dig_c;
  int unsigned       slot_c;
  int unsigned       nib_c;
  logic [7:0]        char_c;

  // State and output registers
  always_ff @(posedge iCLK_50MHZ) begin
    if (!iRST_N) begin
      state_q  <= ST_PWRUP;
      pw_cnt_q <= '0;
      rf_cnt_q <= '0;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      ready_q  <= 1'b0;
      fdone_q  <= 1'b0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      pw_cnt_q <= pw_cnt_d;
      rf_cnt_q <= rf_cnt_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      ready_q  <= ready_d;
      fdone_q  <= fdone_d;
      shadow_q <= shadow_d;
    end
  end

  // Sequencer: one byte in flight at a time, pend_q marks an issued write
  always_comb begin
    state_d  = state_q;
    pw_cnt_d = pw_cnt_q;
    rf_cnt_d = rf_cnt_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    ready_d  = ready_q;
    fdone_d  = 1'b0;
    shadow_d = shadow_q;
    start_c  = 1'b0;

    // Refresh counter parks at zero, so an overrunning frame retriggers at once
    if (rf_cnt_q != '0) rf_cnt_d = rf_cnt_q - RF_W'(1);

    case (state_q)
      ST_PWRUP: begin
        if (pw_cnt_q == PW_W'(PWRUP_CYC - 1)) begin
          state_d = ST_INIT;
          idx_d   = '0;
          pend_d  = 1'b0;
        end else begin
          pw_cnt_d = pw_cnt_q + PW_W'(1);
        end
      end
      ST_INIT, ST_FRAME: begin
        if (!pend_q) begin
          start_c = 1'b1;
          pend_d  = 1'b1;
        end else if (wr_done) begin
          pend_d = 1'b0;
          if (state_q == ST_INIT && idx_q == IDX_W'(INIT_BYTES - 1)) begin
            ready_d = 1'b1;
            state_d = ST_IDLE;
          end else if (state_q == ST_FRAME && idx_q == IDX_W'(FRAME_BYTES - 1)) begin
            fdone_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_IDLE: begin
        if (iEN && rf_cnt_q == '0) begin
          shadow_d = iCH_DATA;
          rf_cnt_d = RF_W'(REFRESH_CYC - 1);
          idx_d    = '0;
          state_d  = ST_FRAME;
        end
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  // Character generator: frame index -> line/column -> field/position -> ASCII
  always_comb begin
    line_c  = (idx_q >= IDX_W'(LINE2_IDX));
    col_c   = line_c ? 4'(idx_q - IDX_W'(LINE2_IDX + 1)) : 4'(idx_q - IDX_W'(1));
    field_c = {line_c, col_c[3]};
    pos_c   = col_c[2:0];
    dig_c   = 1'b0;
    slot_c  = 0;
    nib_c   = 0;
    char_c  = ASCII_SPACE;
    if (32'(field_c) < NUM_CH) begin
`ifdef LCD_LABEL_EN
      if (pos_c < 3'd2) begin
        char_c = label_char(field_c, pos_c[0]);
      end else if (pos_c == 3'd2) begin
        char_c = ASCII_COLON;
      end else if (32'(pos_c) - 32'd3 < DIGITS) begin
        dig_c  = 1'b1;
        slot_c = 32'(pos_c) - 32'd3;
      end
`else
      if (32'(pos_c) < DIGITS) begin
        dig_c  = 1'b1;
        slot_c = 32'(pos_c);
      end
`endif
    end
    // Slot 0 is the most-significant digit of the channel
    if (dig_c) begin
      nib_c  = 32'(field_c) * DIGITS + (DIGITS - 1 - slot_c);
      char_c = hex2ascii(4'(shadow_q >> (nib_c * 4)));
    end
  end

  // Byte selection for the current init/frame index
  always_comb begin
    byte_rs_c   = 1'b0;
    byte_data_c = FUNC_SET;
    byte_wait_c = WAIT_W'(CHAR_WAIT_CYC);
    if (state_q == ST_INIT) begin
      case (idx_q)
        IDX_W'(0): byte_data_c = FUNC_SET;
        IDX_W'(1): byte_data_c = DISP_ON;
        IDX_W'(2): begin
          byte_data_c = CLEAR;
          byte_wait_c = WAIT_W'(CLR_WAIT_CYC);
        end
        default:   byte_data_c = ENTRY;
      endcase
    end else if (idx_q == '0) begin
      byte_data_c = LINE1;
    end else if (idx_q == IDX_W'(LINE2_IDX)) begin
      byte_data_c = LINE2;
    end else begin
      byte_rs_c   = 1'b1;
      byte_data_c = char_c;
    end
  end

  lcd_write_strobe #(
    .E_PULSE_CYC (E_PULSE_CYC),
    .WAIT_W      (WAIT_W)
  ) u_strobe (
    .clk      (iCLK_50MHZ),
    .rst_n    (iRST_N),
    .start    (start_c),
    .rs       (byte_rs_c),
    .data     (byte_data_c),
    .wait_cyc (byte_wait_c),
    .done     (wr_done),
    .lcd_rs   (LCD_RS),
    .lcd_data (LCD_DATA),
    .lcd_e    (LCD_E)
  );

  assign oREADY      = ready_q;
  assign oFRAME_DONE = fdone_q;
  assign LCD_RW      = 1'b0;

endmodule

// File: tb/tb_lcd_multichan_display.sv
// Directed bench for lcd_multichan_display: a 4-channel/2-digit instance and a
// 3-channel/3-digit instance share clock, reset, enable and run in lockstep.
// Expected screen contents follow LCD_LABEL_EN when it is defined for the build.
module tb_lcd_multichan_display;

  localparam int unsigned E_P = 2;
  localparam int unsigned CW  = 4;
  localparam int unsigned CLW = 8;
  localparam int unsigned PW  = 20;
  localparam int unsigned RF  = 400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] data4;
  logic [35:0] data3;

  logic       ready0, fd0, rs0, rw0, e0;
  logic [7:0] d0;
  logic       ready3, fd3, rs3, rw3, e3;
  logic [7:0] d3;

  always #5 clk = ~clk;

  lcd_multichan_display #(
    .NUM_CH(4), .DIGITS(2), .E_PULSE_CYC(E_P), .CHAR_WAIT_CYC(CW),
    .CLR_WAIT_CYC(CLW), .PWRUP_CYC(PW), .REFRESH_CYC(RF)
  ) dut (
    .iCLK_50MHZ(clk), .iRST_N(rst_n), .iEN(en), .iCH_DATA(data4),
    .oREADY(ready0), .oFRAME_DONE(fd0), .LCD_DATA(d0), .LCD_RS(rs0),
    .LCD_RW(rw0), .LCD_E(e0)
  );

  lcd_multichan_display #(
    .NUM_CH(3), .DIGITS(3), .E_PULSE_CYC(E_P), .CHAR_WAIT_CYC(CW),
    .CLR_WAIT_CYC(CLW), .PWRUP_CYC(PW), .REFRESH_CYC(RF)
  ) dut3 (
    .iCLK_50MHZ(clk), .iRST_N(rst_n), .iEN(en), .iCH_DATA(data3),
    .oREADY(ready3), .oFRAME_DONE(fd3), .LCD_DATA(d3), .LCD_RS(rs3),
    .LCD_RW(rw3), .LCD_E(e3)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte capture on each LCD_E rise, plus strobe-shape watchdogs
  logic [8:0] q0[$];
  logic [8:0] q3[$];
  int         tq0[$];
  logic       e0_prev = 1'b0;
  logic       e3_prev = 1'b0;
  logic [8:0] held0 = '0;
  int         len0 = 0;
  int         rises0 = 0;
  int         stab_err = 0;
  int         pulse_err = 0;

  always @(negedge clk) begin
    if (e0 === 1'b1 && e0_prev !== 1'b1) begin
      q0.push_back({rs0, d0});
      tq0.push_back(cyc);
      held0 = {rs0, d0};
      len0 = 1;
      rises0++;
    end else if (e0 === 1'b1 && e0_prev === 1'b1) begin
      len0++;
      if ({rs0, d0} !== held0) stab_err++;
    end else if (e0 === 1'b0 && e0_prev === 1'b1 && rst_n === 1'b1 && len0 != E_P) begin
      pulse_err++;
    end
    e0_prev = e0;
    if (e3 === 1'b1 && e3_prev !== 1'b1) q3.push_back({rs3, d3});
    e3_prev = e3;
  end

  // Expected frame: LINE1 cmd, 16 data chars, LINE2 cmd, 16 data chars
  function automatic logic [305:0] mk(input string a, input string b);
    logic [305:0] v;
    v = '0;
    v[8:0] = {1'b0, 8'h80};
    for (int i = 0; i < 16; i++) v[(1 + i) * 9 +: 9] = {1'b1, a[i]};
    v[17 * 9 +: 9] = {1'b0, 8'hC0};
    for (int i = 0; i < 16; i++) v[(18 + i) * 9 +: 9] = {1'b1, b[i]};
    return v;
  endfunction

  task automatic grab(input int which, output logic [305:0] v, output int n);
    v = '0;
    n = (which == 0) ? q0.size() : q3.size();
    for (int j = 0; j < 34; j++) begin
      if (j < n) v[j * 9 +: 9] = (which == 0) ? q0[j] : q3[j];
    end
  endtask

  task automatic wait_fd(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (fd0 === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rises(input int n, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (q0.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  function automatic logic [35:0] init_got();
    logic [35:0] g;
    g = '0;
    for (int j = 0; j < 4; j++) if (j < q0.size()) g[(3 - j) * 9 +: 9] = q0[j];
    return g;
  endfunction

  localparam logic [35:0] INIT_SEQ = {9'h038, 9'h00C, 9'h001, 9'h006};

  logic [305:0] exp_a4, exp_a3, exp_b4, exp_b3;

  initial begin
`ifdef LCD_LABEL_EN
    exp_a4 = mk("VI:01   VO:7F   ", "IO:3C   TP:A5   ");
    exp_a3 = mk("VI:1B2  VO:C3D  ", "IO:4E5          ");
    exp_b4 = mk("VI:62   VO:B4   ", "IO:9E   TP:0F   ");
    exp_b3 = mk("VI:09C  VO:FFF  ", "IO:8A0          ");
`else
    exp_a4 = mk("01      7F      ", "3C      A5      ");
    exp_a3 = mk("1B2     C3D     ", "4E5             ");
    exp_b4 = mk("62      B4      ", "9E      0F      ");
    exp_b3 = mk("09C     FFF     ", "8A0             ");
`endif
  end

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    data4 = 32'hA53C_7F01;
    data3 = 36'h4E5_C3D_1B2;
    repeat (3) @(negedge clk);
    total++;
    if ({e0, rs0, d0, ready0, fd0, rw0} !== 13'h0)
      $display("FAIL reset_outs4 got=%h exp=0", {e0, rs0, d0, ready0, fd0, rw0});
    else passed++;
    total++;
    if ({e3, rs3, d3, ready3, fd3, rw3} !== 13'h0)
      $display("FAIL reset_outs3 got=%h exp=0", {e3, rs3, d3, ready3, fd3, rw3});
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    int r;
    bit ok;
    int g_clr, g_chr;
    r = rises0;
    repeat (20) @(negedge clk);
    total++;
    if (rises0 - r != 0 || e0 !== 1'b0) $display("FAIL pwrup_quiet rises=%0d exp=0", rises0 - r);
    else passed++;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ready0 === 1'b1) begin ok = 1'b1; break; end
    end
    total++;
    if (ok !== 1'b1) $display("FAIL init_ready_timeout got=%b exp=1", ok);
    else passed++;
    total++;
    if (q0.size() != 4 || e0 !== 1'b0) $display("FAIL ready_after_4th writes=%0d exp=4", q0.size());
    else passed++;
    total++;
    if (init_got() !== INIT_SEQ) $display("FAIL init_bytes got=%h exp=%h", init_got(), INIT_SEQ);
    else passed++;
    g_clr = 0;
    g_chr = 0;
    if (tq0.size() >= 4) begin
      g_clr = tq0[3] - tq0[2];
      g_chr = tq0[1] - tq0[0];
    end
    total++;
    if (g_clr < int'(1 + E_P + CLW)) $display("FAIL clear_wait gap=%0d exp>=%0d", g_clr, 1 + E_P + CLW);
    else passed++;
    total++;
    if (g_chr < int'(1 + E_P + CW)) $display("FAIL char_wait gap=%0d exp>=%0d", g_chr, 1 + E_P + CW);
    else passed++;
    total++;
    if (ready3 !== 1'b1) $display("FAIL init_ready3 got=%b exp=1", ready3);
    else passed++;
  endtask

  task automatic test_frame();
    bit ok;
    logic [305:0] g;
    int n;
    q0.delete();
    q3.delete();
    en = 1'b1;
    wait_fd(1000, ok);
    total++;
    if (ok !== 1'b1 || q0.size() != 34 || e0 !== 1'b0)
      $display("FAIL frame1_done ok=%b writes=%0d exp=34", ok, q0.size());
    else passed++;
    grab(0, g, n);
    total++;
    if (g !== exp_a4) $display("FAIL frame1_ch4 got=%h exp=%h", g, exp_a4);
    else passed++;
    grab(1, g, n);
    total++;
    if (g !== exp_a3) $display("FAIL frame1_ch3 got=%h exp=%h", g, exp_a3);
    else passed++;
    @(negedge clk);
    total++;
    if (fd0 !== 1'b0) $display("FAIL frame_done_pulse got=%b exp=0", fd0);
    else passed++;
  endtask

  task automatic test_snapshot();
    bit ok;
    logic [305:0] g;
    int n;
    q0.delete();
    q3.delete();
    wait_rises(3, 1000, ok);
    total++;
    if (ok !== 1'b1) $display("FAIL refresh_start got=%b exp=1", ok);
    else passed++;
    data4 = 32'h0F9E_B462;
    data3 = 36'h8A0_FFF_09C;
    wait_fd(1000, ok);
    grab(0, g, n);
    total++;
    if (ok !== 1'b1 || g !== exp_a4) $display("FAIL snapshot_old got=%h exp=%h", g, exp_a4);
    else passed++;
    q0.delete();
    q3.delete();
    wait_fd(1000, ok);
    grab(0, g, n);
    total++;
    if (ok !== 1'b1 || g !== exp_b4) $display("FAIL snapshot_new4 got=%h exp=%h", g, exp_b4);
    else passed++;
    grab(1, g, n);
    total++;
    if (g !== exp_b3) $display("FAIL snapshot_new3 got=%h exp=%h", g, exp_b3);
    else passed++;
  endtask

  task automatic test_en_low();
    bit ok;
    logic [305:0] g;
    int n, r;
    q0.delete();
    q3.delete();
    wait_rises(5, 1000, ok);
    en = 1'b0;
    wait_fd(1000, ok);
    grab(0, g, n);
    total++;
    if (ok !== 1'b1 || n != 34 || g !== exp_b4)
      $display("FAIL en_low_completes writes=%0d got=%h exp=%h", n, g, exp_b4);
    else passed++;
    r = rises0;
    repeat (3 * RF) @(negedge clk);
    total++;
    if (rises0 - r != 0) $display("FAIL en_low_idle rises=%0d exp=0", rises0 - r);
    else passed++;
    q0.delete();
    q3.delete();
    en = 1'b1;
    wait_rises(1, 20, ok);
    total++;
    if (ok !== 1'b1) $display("FAIL en_rise_start got=%b exp=1", ok);
    else passed++;
    wait_fd(1000, ok);
    grab(0, g, n);
    total++;
    if (ok !== 1'b1 || g !== exp_b4) $display("FAIL en_rise_frame got=%h exp=%h", g, exp_b4);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok, early;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (e0 === 1'b1) begin ok = 1'b1; break; end
    end
    total++;
    if (ok !== 1'b1) $display("FAIL mid_reset_find_e got=%b exp=1", ok);
    else passed++;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({e0, rs0, d0, ready0, fd0} !== 12'h0 || {e3, rs3, d3, ready3, fd3} !== 12'h0)
      $display("FAIL mid_reset_outs got=%h exp=0", {e0, rs0, d0, ready0, fd0});
    else passed++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q0.delete();
    tq0.delete();
    ok    = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ready0 === 1'b1) begin
        ok = 1'b1;
        if (q0.size() != 4) early = 1'b1;
        break;
      end
    end
    total++;
    if (ok !== 1'b1 || early !== 1'b0)
      $display("FAIL reinit_ready ok=%b writes=%0d exp=4", ok, q0.size());
    else passed++;
    total++;
    if (init_got() !== INIT_SEQ) $display("FAIL reinit_bytes got=%h exp=%h", init_got(), INIT_SEQ);
    else passed++;
  endtask

  task automatic test_strobe_shape();
    total++;
    if (stab_err != 0) $display("FAIL data_stable_e_high got=%0d exp=0", stab_err);
    else passed++;
    total++;
    if (pulse_err != 0) $display("FAIL e_pulse_width errors=%0d exp=0", pulse_err);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_init();
    test_frame();
    test_snapshot();
    test_en_low();
    test_reset_mid();
    test_strobe_shape();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
